tx_arbiter: RTL
===============

# tx_arbiter

Round-robin controller that shares one UART transmit engine between four byte-producing requesters. It sits between the requesters (processor port writes, hardware status sources, loopback echo) and the transmit engine's `load`/`data`/`TxRDY` interface. It issues exactly one load pulse per granted byte and tracks the engine through busy and done. It also recovers from an engine that never acknowledges a load.

## Interface
- `BUSY_TO`, default 16: cycles allowed after a load for the engine's `TxRDY` to fall before the transfer is abandoned; legal range 2..255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; 0 blocks new grants, a transfer in progress completes.
- `req`  in  4  per-requester level request; bit i = requester i.
- `req_data`  in  32  requester byte bus; byte i = bits [8i+7:8i].
- `ack`  out  4  one-hot, one-cycle pulse: byte of requester i accepted.
- `TxRDY`  in  1  transmit engine ready (1 = idle, can accept load).
- `load`  out  1  one-cycle load strobe to transmit engine.
- `tx_data`  out  8  byte presented to transmit engine; valid while `load`=1.
- `grant_id`  out  2  index of the current or most recent grant.
- `busy`  out  1  1 whenever state ≠ IDLE.
- `err`  out  1  one-cycle pulse on busy-timeout abandonment.

## Operation
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- **IDLE.**
  - If `en`=1, `TxRDY`=1 and `req`≠0, choose the winner by round-robin.
  - Search starts at `(last_grant+1) mod 4` and ascends with wrap.
  - On the edge, register the winner into `grant_id`/`last_grant` and capture its `req_data` byte into `tx_data`.
  - Go to LOAD. Otherwise stay in IDLE.
- **LOAD.** Exactly one cycle. `load`=1 and `ack[grant_id]`=1 together. Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY.**
  - If `TxRDY`=0, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches `BUSY_TO`-1 with `TxRDY` still 1, pulse `err` and go to IDLE. The ack already issued stands, and the byte is not retried.
- **WAIT_DONE.** Wait for `TxRDY`=1, then go to IDLE. There is no timeout here, because frame length depends on the engine's baud setting.
- **Requester rules.**
  - Hold `req` and its byte stable from assertion until `ack`.
  - The cycle after `ack`, the requester may drop `req`, or keep it high with the next byte to queue another transfer.
  - A requester that drops `req` before being granted is simply not granted; no error is raised.
- **Fairness.** A requester that has just been served has lowest priority at the next arbitration. With all four requesting, grants rotate 0,1,2,3,0,…
- **`en` deasserted** in LOAD, WAIT_BUSY or WAIT_DONE: the transfer completes normally and the block parks in IDLE.
- **`TxRDY`=0 while IDLE** (engine busy from elsewhere): no grant is made.
- **Counter width:** 8 bits, saturating is not required.
- **Reset mid-operation:** return to IDLE immediately. No `load`, `ack` or `err` is emitted during or after reset.
- **Reset values:**
  - state = IDLE
  - `load`=0, `ack`=0, `err`=0, `busy`=0
  - `tx_data`=8'h00, `grant_id`=2'd3
  - `last_grant`=3, so requester 0 wins first.

## Timing
- **Grant latency.** Given `req`, `en` and `TxRDY` all high in IDLE in cycle n:
  - `tx_data` is valid, and `load`=`ack`=1, in cycle n+1.
  - `busy`=1 from cycle n+1.
- **Data sampling.** `req_data` is sampled on the edge ending cycle n.
- **Minimum spacing between loads:** 4 cycles (LOAD, WAIT_BUSY, WAIT_DONE, IDLE), plus the engine's frame time.
- **Timeout abandonment:**
  - `err` pulses in the cycle after the counter reaches `BUSY_TO`-1.
  - With `TxRDY` stuck at 1, the LOAD cycle is followed by `BUSY_TO` cycles in WAIT_BUSY; `err` and the return to IDLE land on the last of these.
- **Pulse widths.** `load`, `ack` and `err` are registered outputs and are never high for more than one consecutive cycle.

## Test plan
- **Reset defaults.** Assert `rst` mid-cycle -> all outputs drop asynchronously to their reset values; `grant_id`=3.
- **Single request.**
  - Stimulus: `req`=4'b0100, byte2=8'hA5, `TxRDY` high; engine model drops `TxRDY` 1 cycle after `load` and restores it after 20 cycles.
  - Response: exactly one `load` with `tx_data`=8'hA5; `ack`=4'b0100 in the same cycle; `busy` high until the cycle after `TxRDY` returns.
- **Round-robin.** `req`=4'hF held, each requester supplying a distinct byte -> grant order 0,1,2,3,0; `tx_data` sequence matches bytes 0,1,2,3,0.
- **Engine not ready / `en` low.**
  - `TxRDY` held 0 with `req`=4'b0001 -> no `load` for 50 cycles.
  - Then raise `TxRDY` -> `load` follows 1 cycle later.
  - Repeat with `en`=0 -> no `load` at all.
- **Timeout.** `BUSY_TO`=16, `TxRDY` stuck 1 after `load` -> one `err` pulse on the 16th cycle after LOAD, then IDLE; a new grant proceeds normally.
- **Reset during WAIT_DONE.** Assert reset, release, keep `req`=4'b0010 -> IDLE; the next grant goes to requester 1 (search starts at 0, requester 0 idle), with `load` 1 cycle after `TxRDY` is seen high.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Requester/engine-side bundle for the UART transmit arbiter.
// The arbiter takes the slave view; the requester/engine side takes the master view.
interface tx_arbiter_if;
   logic        en;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        TxRDY;
   logic        load;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err;

   modport master (
      output en, req, req_data, TxRDY,
      input  ack, load, tx_data, grant_id, busy, err
   );

   modport slave (
      input  en, req, req_data, TxRDY,
      output ack, load, tx_data, grant_id, busy, err
   );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine among four byte requesters,
// with a load-acknowledge timeout for an engine that never goes busy.
module tx_arbiter #(
   parameter int BUSY_TO = 16
) (
   input  logic          clk,
   input  logic          rst,
   tx_arbiter_if.slave   bus
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD      = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   // err must be visible in the same cycle the FSM lands back in IDLE, so the
   // registered decision is taken one count early.
   localparam logic [7:0] TO_LAST = 8'(BUSY_TO - 2);

   logic [1:0] state;
   logic [7:0] cnt;
   logic [2:0] pick;

   // Returns {found, index}; search starts just after the last winner and wraps.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb pick = rr_pick(bus.req, bus.grant_id);

   assign bus.busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= 8'd0;
         bus.load     <= 1'b0;
         bus.ack      <= 4'b0000;
         bus.err      <= 1'b0;
         bus.tx_data  <= 8'h00;
         bus.grant_id <= 2'd3;
      end else begin
         bus.load <= 1'b0;
         bus.ack  <= 4'b0000;
         bus.err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.en && bus.TxRDY && pick[2]) begin
                  bus.grant_id <= pick[1:0];
                  bus.tx_data  <= bus.req_data[{pick[1:0], 3'b000} +: 8];
                  bus.load     <= 1'b1;
                  bus.ack      <= 4'b0001 << pick[1:0];
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt   <= 8'd0;
               state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!bus.TxRDY) begin
                  state <= ST_WAIT_DONE;
               end else if (cnt == TO_LAST) begin
                  bus.err <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_WAIT_DONE: begin
               // Frame length depends on baud rate, so no timeout here.
               if (bus.TxRDY) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
